mips_run_ctrl: RTL and testbench
================================

# mips_run_ctrl

Parametrised run controller placed between the simulation/board top and the MIPS core. It replaces fixed-delay reset and stop timing with a synthesizable sequencer. It holds the core in reset for a programmable number of cycles, then gates the core's clock enable in free-run or single-step mode. It ends the run on a self-loop halt (PC unchanged for `HALT_REPEAT` enabled cycles) or when a cycle budget is exhausted, and reports a cycle count and the final PC.

## Interface
Parameters:
- `PC_W`, 32, width of monitored PC and `final_pc`
- `CNT_W`, 32, width of cycle counter and `max_cycles`
- `RESET_CYCLES`, 4, cycles `core_reset` is held after `start` (≥1)
- `HALT_REPEAT`, 2, consecutive enabled cycles with unchanged PC that declare a halt (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low controller reset
- `start` in 1: pulse; starts a run from IDLE, HALTED or TIMEOUT
- `step_mode` in 1: 1 = single-step, 0 = free-run; sampled every cycle in RUN/STEP
- `step_req` in 1: pulse; grants one enabled core cycle in step mode
- `max_cycles` in CNT_W: budget of enabled cycles; 0 = unlimited; latched at `start`
- `pc` in PC_W: core's current PC
- `core_reset` out 1: active-high synchronous reset to core
- `core_en` out 1: core clock enable (state updates only when 1)
- `cycle_cnt` out CNT_W: enabled core cycles in current run
- `final_pc` out PC_W: PC captured on run end
- `busy`, `halted`, `timeout` out 1: status

## Operation
- States: IDLE, RST, RUN, STEP, HALTED, TIMEOUT.
- IDLE: outputs at reset values. `start` → RST, latch `max_cycles`, clear `cycle_cnt` and the reset counter.
- RST: `core_reset`=1 for exactly `RESET_CYCLES` cycles. Then go to RUN if `step_mode`=0, else STEP.
- RUN: `core_en`=1 every cycle. `step_mode`=1 → STEP next cycle.
- STEP: `core_en`=1 only in the cycle after a sampled `step_req` (one pulse per request). Requests during that enabled cycle are dropped. `step_mode`=0 → RUN.
- Every enabled cycle increments `cycle_cnt`; the counter saturates at all-ones.
- Halt detect: compare `pc` with a registered previous-enabled-cycle PC. The repeat counter increments on equal and clears on differ. It reaches `HALT_REPEAT` → HALTED, `final_pc`=`pc`, `core_en` drops next cycle.
- Timeout: `max_cycles`≠0 and the enabled-cycle count reaches `max_cycles` → TIMEOUT, `final_pc`=`pc`.
- Halt and timeout in the same cycle: HALTED wins, `timeout` stays 0.
- HALTED/TIMEOUT: status held, `core_en`=0. `start` → RST (restart). `start` in RST/RUN/STEP is ignored.
- `busy`=1 in RST, RUN, STEP.
- The PC comparison does not begin until the first enabled cycle after RST; the first sample only seeds the previous-PC register.

## Timing
- Reset values (while `reset`=0, asynchronous): state IDLE, `core_reset`=1, `core_en`=0, `cycle_cnt`=0, `final_pc`=0, `busy`/`halted`/`timeout`=0.
- Outside RST and IDLE, `core_reset`=0. In IDLE it is held at 1, so the core is never free-running.
- Deassertion of `reset` is synchronised by the user; no internal synchroniser.
- All outputs are registered.
- `start` at edge k → `core_reset`=1 during cycles k+1..k+RESET_CYCLES, and `core_en`=1 from cycle k+RESET_CYCLES+1 (free-run).
- Step latency: `step_req` at edge k → `core_en`=1 for exactly cycle k+1.
- Status latency: the halt/timeout decision is made at the edge ending the qualifying enabled cycle. Status flags are set and `core_en`=0 in the following cycle.
- `reset` asserted mid-run → immediate IDLE; counters cleared.

## Structure
- Shared package `mips_tb_pkg`: state enum (IDLE=0, RST=1, RUN=2, STEP=3, HALTED=4, TIMEOUT=5) and default parameter constants, reused by benches.
- One natural sub-module: `halt_detect` (previous-PC register plus repeat counter, input `en`/`pc`, output `hit`).
- The top holds the FSM, counters and output registers.

## Test plan
- RESET_CYCLES=4, `start`, free-run, `pc` increments by 4 from 0x3000 → `core_reset` high exactly 4 cycles; `cycle_cnt`=10 after 10 enabled cycles; no halt.
- PC sequence 0x3000, 0x3004, 0x3008, 0x3008, 0x3008 with HALT_REPEAT=2 → `halted`=1, `final_pc`=0x3008, `cycle_cnt`=5, `core_en`=0 afterward.
- `max_cycles`=7, PC always increments → `timeout`=1 with `cycle_cnt`=7, `final_pc`=PC of the 7th cycle.
- Step mode, three `step_req` pulses spaced 5 cycles apart → exactly 3 single-cycle `core_en` pulses, `cycle_cnt`=3. A back-to-back request pair yields 1 pulse.
- Halt and timeout in the same cycle (`max_cycles`=5, PC repeats at cycles 4–5) → `halted`=1, `timeout`=0.
- `reset` pulsed low during RUN → all outputs return to reset values that same cycle. A subsequent `start` reruns RST cleanly and `cycle_cnt` restarts at 0.

Source files
------------

// File: rtl/mips_tb_pkg.sv
// mips_tb_pkg
// Shared definitions for the MIPS run controller and the benches that drive it.
//   - run_state_e : run-controller state encoding (IDLE=0 .. TIMEOUT=5)
//   - DEF_*       : default parameter values for the controller
package mips_tb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST     = 3'd1,
    RUN     = 3'd2,
    STEP    = 3'd3,
    HALTED  = 3'd4,
    TIMEOUT = 3'd5
  } run_state_e;

  localparam int DEF_PC_W         = 32;
  localparam int DEF_CNT_W        = 32;
  localparam int DEF_RESET_CYCLES = 4;
  localparam int DEF_HALT_REPEAT  = 2;

endpackage

// File: rtl/halt_detect.sv
// halt_detect
// Detects a self-loop halt: the PC stays unchanged for HALT_REPEAT consecutive
// enabled cycles. The first enabled cycle after a clear only seeds the
// previous-PC register; comparisons start on the following enabled cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (held while the core is in reset)
//   en         : core clock enable for the current cycle
//   pc         : core PC in the current cycle
//   hit        : halt condition met in this enabled cycle (combinational)
module halt_detect #(
  parameter int PC_W        = 32,
  parameter int HALT_REPEAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [PC_W-1:0] pc,
  output logic            hit
);

  localparam int REP_W = $clog2(HALT_REPEAT + 1);
  localparam logic [REP_W:0] HALT_LIM = (REP_W + 1)'(HALT_REPEAT);
  localparam logic [REP_W:0] REP_ONE  = (REP_W + 1)'(1);

  logic [PC_W-1:0]  prev_pc_r;
  logic [REP_W-1:0] rep_r;
  logic             seeded_r;
  logic             pc_eq_s;
  logic [REP_W:0]   rep_inc_s;

  // compare against the previous enabled-cycle PC and evaluate the repeat limit
  always_comb begin
    pc_eq_s   = (pc == prev_pc_r);
    rep_inc_s = {1'b0, rep_r} + REP_ONE;
    hit       = en && seeded_r && pc_eq_s && (rep_inc_s >= HALT_LIM);
  end

  // previous-PC register and consecutive-repeat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pc_r <= {PC_W{1'b0}};
      rep_r     <= {REP_W{1'b0}};
      seeded_r  <= 1'b0;
    end else if (clr) begin
      prev_pc_r <= {PC_W{1'b0}};
      rep_r     <= {REP_W{1'b0}};
      seeded_r  <= 1'b0;
    end else if (en) begin
      prev_pc_r <= pc;
      seeded_r  <= 1'b1;
      if (!seeded_r) begin
        rep_r <= {REP_W{1'b0}};
      end else if (!pc_eq_s) begin
        rep_r <= {REP_W{1'b0}};
      end else if (rep_inc_s >= HALT_LIM) begin
        // saturate at the limit; the controller stops the run on this cycle
        rep_r <= rep_r;
      end else begin
        rep_r <= rep_inc_s[REP_W-1:0];
      end
    end else begin
      prev_pc_r <= prev_pc_r;
      rep_r     <= rep_r;
      seeded_r  <= seeded_r;
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl
// Run controller between the board/sim top and the MIPS core. Holds the core
// in reset for RESET_CYCLES after start, then enables it in free-run or
// single-step mode, and ends the run on a self-loop halt or cycle budget.
// Ports:
//   clk, reset  : clock, asynchronous active-low controller reset
//   start       : pulse, begins a run from IDLE/HALTED/TIMEOUT
//   step_mode   : 1 = single-step, 0 = free-run
//   step_req    : pulse, one enabled core cycle in step mode
//   max_cycles  : enabled-cycle budget (0 = unlimited), latched at start
//   pc          : current core PC
//   core_reset  : active-high reset to the core
//   core_en     : core clock enable
//   cycle_cnt   : enabled cycles in the current run (saturating)
//   final_pc    : PC captured when the run ends
//   busy, halted, timeout : status
module mips_run_ctrl
  import mips_tb_pkg::*;
#(
  parameter int PC_W         = DEF_PC_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int HALT_REPEAT  = DEF_HALT_REPEAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step_req,
  input  logic [CNT_W-1:0] max_cycles,
  input  logic [PC_W-1:0]  pc,
  output logic             core_reset,
  output logic             core_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [PC_W-1:0]  final_pc,
  output logic             busy,
  output logic             halted,
  output logic             timeout
);

  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_ONE  = RST_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  run_state_e       state_r;
  logic [RST_W-1:0] rst_cnt_r;
  logic [CNT_W-1:0] max_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             hit_s;
  logic             halt_s;
  logic             tmo_s;
  logic             hd_clr_s;

  // saturating increment: an all-ones count stays put
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // end-of-run decisions for the current enabled cycle
  always_comb begin
    cnt_next_s = sat_inc(cycle_cnt);
    halt_s     = core_en & hit_s;
    tmo_s      = 1'b0;
    if (core_en && (max_r != CNT_ZERO) && (cnt_next_s == max_r)) begin
      tmo_s = 1'b1;
    end else begin
      tmo_s = 1'b0;
    end
    // keep the halt detector unseeded until the first enabled cycle of a run
    hd_clr_s = (state_r == RST);
  end

  halt_detect #(
    .PC_W        (PC_W),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt_detect (
    .clk   (clk),
    .rst_n (reset),
    .clr   (hd_clr_s),
    .en    (core_en),
    .pc    (pc),
    .hit   (hit_s)
  );

  // run sequencer with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      rst_cnt_r  <= {RST_W{1'b0}};
      max_r      <= CNT_ZERO;
      cycle_cnt  <= CNT_ZERO;
      final_pc   <= {PC_W{1'b0}};
      core_reset <= 1'b1;
      core_en    <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, HALTED, TIMEOUT: begin
          core_en <= 1'b0;
          if (start) begin
            state_r    <= RST;
            max_r      <= max_cycles;
            cycle_cnt  <= CNT_ZERO;
            rst_cnt_r  <= {RST_W{1'b0}};
            core_reset <= 1'b1;
            busy       <= 1'b1;
            halted     <= 1'b0;
            timeout    <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end

        RST: begin
          if (rst_cnt_r == RST_LAST) begin
            core_reset <= 1'b0;
            if (step_mode) begin
              state_r <= STEP;
              core_en <= 1'b0;
            end else begin
              state_r <= RUN;
              core_en <= 1'b1;
            end
          end else begin
            rst_cnt_r <= rst_cnt_r + RST_ONE;
          end
        end

        RUN, STEP: begin
          if (core_en) begin
            cycle_cnt <= cnt_next_s;
          end else begin
            cycle_cnt <= cycle_cnt;
          end

          if (halt_s) begin
            // halt has priority over a simultaneous budget expiry
            state_r  <= HALTED;
            core_en  <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b1;
            final_pc <= pc;
          end else if (tmo_s) begin
            state_r  <= TIMEOUT;
            core_en  <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b1;
            final_pc <= pc;
          end else if (step_mode) begin
            // a request seen during an enabled cycle is dropped
            state_r <= STEP;
            core_en <= step_req & ~core_en;
          end else begin
            state_r <= RUN;
            core_en <= 1'b1;
          end
        end

        default: begin
          state_r    <= IDLE;
          core_reset <= 1'b1;
          core_en    <= 1'b0;
          busy       <= 1'b0;
          halted     <= 1'b0;
          timeout    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl
// Self-checking bench for mips_run_ctrl: directed runs from the test plan plus
// randomized PC sequences, checked against a sequence-level reference model.
module tb_mips_run_ctrl;

  localparam int PC_W  = 32;
  localparam int CNT_W = 32;
  localparam int RC    = 4;
  localparam int HR    = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             step_mode;
  logic             step_req;
  logic [CNT_W-1:0] max_cycles;
  logic [PC_W-1:0]  pc;
  logic             core_reset;
  logic             core_en;
  logic [CNT_W-1:0] cycle_cnt;
  logic [PC_W-1:0]  final_pc;
  logic             busy;
  logic             halted;
  logic             timeout;

  mips_run_ctrl #(
    .PC_W         (PC_W),
    .CNT_W        (CNT_W),
    .RESET_CYCLES (RC),
    .HALT_REPEAT  (HR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .step_mode  (step_mode),
    .step_req   (step_req),
    .max_cycles (max_cycles),
    .pc         (pc),
    .core_reset (core_reset),
    .core_en    (core_en),
    .cycle_cnt  (cycle_cnt),
    .final_pc   (final_pc),
    .busy       (busy),
    .halted     (halted),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // PC presented during the i-th enabled cycle of a run is seq[i]
  logic [PC_W-1:0] seq [0:63];
  int idx;
  int en_total;
  int cur_run;
  int max_run;

  // snapshot of outputs taken at the falling edge
  logic             s_en, s_rst, s_busy, s_halt, s_to;
  logic [CNT_W-1:0] s_cnt;
  logic [PC_W-1:0]  s_fpc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: sample at negedge, then advance the core PC if that cycle was enabled
  task automatic tick();
    @(negedge clk);
    s_en   = core_en;
    s_rst  = core_reset;
    s_busy = busy;
    s_halt = halted;
    s_to   = timeout;
    s_cnt  = cycle_cnt;
    s_fpc  = final_pc;
    if (s_en) begin
      en_total++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
    @(posedge clk);
    #1;
    if (s_en) begin
      if (idx < 63) idx++;
      pc = seq[idx];
    end
  endtask

  task automatic set_incr(input logic [PC_W-1:0] base, input int tail_from);
    for (int i = 0; i < 64; i++) begin
      if (i < tail_from || i == 0) seq[i] = base + PC_W'(4 * i);
      else seq[i] = seq[i-1];
    end
  endtask

  task automatic set_random();
    seq[0] = 32'h0000_3000 + PC_W'(4 * $urandom_range(0, 255));
    for (int i = 1; i < 64; i++) begin
      if (i >= 40 || $urandom_range(0, 3) == 0) seq[i] = seq[i-1];
      else seq[i] = seq[i-1] + 32'd4;
    end
  endtask

  // reference: walk the PC sequence one enabled cycle at a time
  // kind: 1 = halted, 2 = timeout
  task automatic model(input int m, output int kind, output int cnt, output logic [PC_W-1:0] fpc);
    int rep;
    rep  = 0;
    kind = 0;
    cnt  = 0;
    fpc  = '0;
    for (int i = 0; i < 64 && kind == 0; i++) begin
      if (i > 0 && seq[i] == seq[i-1]) rep++;
      else rep = 0;
      if (rep >= HR) begin
        kind = 1; cnt = i + 1; fpc = seq[i];
      end else if (m != 0 && i + 1 == m) begin
        kind = 2; cnt = i + 1; fpc = seq[i];
      end
    end
  endtask

  task automatic run_free(input int m, input string name);
    int kind, exp_cnt, rst_seen, first_en;
    logic [PC_W-1:0] exp_pc;
    bit ended;
    model(m, kind, exp_cnt, exp_pc);
    idx = 0; pc = seq[0]; en_total = 0; cur_run = 0; max_run = 0;
    step_mode = 1'b0; max_cycles = CNT_W'(m);
    start = 1'b1;
    tick();
    start = 1'b0;
    ended = 0; rst_seen = 0; first_en = 0;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (s_rst) rst_seen++;
      if (s_en && first_en == 0) first_en = c;
      check({name, "_cnt_run"}, s_cnt, en_total - (s_en ? 1 : 0));
      if (s_halt || s_to) begin
        ended = 1;
        break;
      end
      check({name, "_busy"}, s_busy, 1);
    end
    check({name, "_ended"}, ended, 1);
    check({name, "_rst_len"}, rst_seen, RC);
    check({name, "_first_en"}, first_en, RC + 1);
    check({name, "_halted"}, s_halt, kind == 1);
    check({name, "_timeout"}, s_to, kind == 2);
    check({name, "_cycle_cnt"}, s_cnt, exp_cnt);
    check({name, "_en_total"}, en_total, exp_cnt);
    check({name, "_final_pc"}, s_fpc, exp_pc);
    check({name, "_en_off"}, s_en, 0);
    check({name, "_busy_off"}, s_busy, 0);
    tick();
    check({name, "_en_held_off"}, s_en, 0);
    check({name, "_status_held"}, {s_halt, s_to}, {kind == 1, kind == 2});
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_core_reset"}, core_reset, 1);
    check({name, "_core_en"}, core_en, 0);
    check({name, "_cycle_cnt"}, cycle_cnt, 0);
    check({name, "_final_pc"}, final_pc, 0);
    check({name, "_status"}, {busy, halted, timeout}, 3'b000);
  endtask

  initial begin
    int n_steps;
    reset = 1'b0; start = 1'b0; step_mode = 1'b0; step_req = 1'b0;
    max_cycles = '0; pc = '0; idx = 0;
    for (int i = 0; i < 64; i++) seq[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_core_reset", core_reset, 1);

    // free-run incrementing PC, halt only on the trailing self-loop
    set_incr(32'h0000_3000, 40);
    run_free(0, "incr");
    // 3000,3004,3008,3008,3008 -> halt after 5 enabled cycles
    set_incr(32'h0000_3000, 3);
    run_free(0, "halt");
    // budget of 7, PC always moving
    set_incr(32'h0000_3000, 40);
    run_free(7, "tmo");
    // halt and budget expire in the same cycle
    set_incr(32'h0000_3000, 3);
    run_free(5, "tie");

    // single-step mode
    for (int i = 0; i < 64; i++) seq[i] = 32'h0000_4000 + PC_W'(4 * i);
    idx = 0; pc = seq[0]; en_total = 0; cur_run = 0; max_run = 0;
    step_mode = 1'b1; max_cycles = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (RC + 3) tick();
    check("step_idle_en", en_total, 0);
    check("step_busy", s_busy, 1);
    n_steps = $urandom_range(3, 5);
    for (int r = 0; r < n_steps; r++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      repeat ($urandom_range(2, 6)) tick();
    end
    check("step_pulses", en_total, n_steps);
    check("step_cnt", s_cnt, n_steps);
    check("step_width", max_run, 1);
    step_req = 1'b1;
    tick();
    tick();
    step_req = 1'b0;
    repeat (4) tick();
    check("pair_pulses", en_total, n_steps + 1);
    check("pair_cnt", s_cnt, n_steps + 1);
    check("pair_width", max_run, 1);

    // back to free-run, then pull reset mid-run
    step_mode = 1'b0;
    repeat (3) tick();
    check("run_en", s_en, 1);
    #3;
    reset = 1'b0;
    #1;
    check_reset_vals("midrun");
    @(posedge clk);
    #1;
    check_reset_vals("midrun_hold");
    reset = 1'b1;
    set_random();
    run_free($urandom_range(0, 30), "restart");

    // randomized runs back to back (restart from HALTED/TIMEOUT)
    for (int t = 0; t < 8; t++) begin
      set_random();
      run_free($urandom_range(0, 30), $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
